// File: rtl/dual_port_ram_be_if.sv
// Bus bundle for dual_port_ram_be: write port, read port, init request and status.
// master drives requests; slave is the RAM.
interface dual_port_ram_be_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  init_start;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] din;
  logic                  write_en;
  logic [NUM_BYTES-1:0]  byte_en;
  logic [ADDR_WIDTH-1:0] raddr;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;

  modport master (
    output init_start, waddr, din, write_en, byte_en, raddr, read_en,
    input  busy, dout, dout_valid
  );

  modport slave (
    input  init_start, waddr, din, write_en, byte_en, raddr, read_en,
    output busy, dout, dout_valid
  );
endinterface

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, read valid, optional output
// register, selectable read-during-write bypass and a zero-initialisation engine.
module dual_port_ram_be #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned OUTPUT_REG = 0,
  parameter int unsigned RDW_BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  dual_port_ram_be_if.slave   bus
);
  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
  logic                  pipe_valid_q, pipe_valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_fire_c;
  logic                  rd_fire_c;
  logic [NUM_BYTES-1:0]  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_waddr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [DATA_WIDTH-1:0] mem_rdata_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  // Init engine owns the write port while in ST_INIT; user traffic only in ST_READY.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    busy_d      = busy_q;
    wr_fire_c   = 1'b0;
    rd_fire_c   = 1'b0;
    mem_we_c    = '0;
    mem_waddr_c = bus.waddr;
    mem_wdata_c = bus.din;
    case (state_q)
      ST_INIT: begin
        mem_we_c    = '1;
        mem_waddr_c = init_addr_q;
        mem_wdata_c = '0;
        if (init_addr_q == TOP_ADDR) begin
          state_d     = ST_READY;
          busy_d      = 1'b0;
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
        end
      end
      ST_READY: begin
        rd_fire_c = bus.read_en;
        if (bus.init_start) begin
          state_d     = ST_INIT;
          init_addr_d = '0;
          busy_d      = 1'b1;
        end else begin
          wr_fire_c = bus.write_en;
          if (bus.write_en) begin
            mem_we_c = bus.byte_en;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Same-address bypass merges only the lanes actually being written this cycle.
  always_comb begin
    mem_rdata_c = mem_q[bus.raddr];
    rd_word_c   = mem_rdata_c;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if ((RDW_BYPASS != 0) && wr_fire_c && bus.byte_en[i] && (bus.waddr == bus.raddr)) begin
        rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_comb begin
    pipe_valid_d = 1'b0;
    pipe_data_d  = pipe_data_q;
    dout_valid_d = 1'b0;
    dout_d       = dout_q;
    if (OUTPUT_REG != 0) begin
      pipe_valid_d = rd_fire_c;
      if (rd_fire_c) begin
        pipe_data_d = rd_word_c;
      end
      dout_valid_d = pipe_valid_q;
      if (pipe_valid_q) begin
        dout_d = pipe_data_q;
      end
    end else begin
      dout_valid_d = rd_fire_c;
      if (rd_fire_c) begin
        dout_d = rd_word_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_addr_q  <= '0;
      busy_q       <= 1'b1;
      pipe_data_q  <= '0;
      pipe_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      busy_q       <= busy_d;
      pipe_data_q  <= pipe_data_d;
      pipe_valid_q <= pipe_valid_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Storage is not reset; the init engine clears it.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (mem_we_c[i]) begin
        mem_q[mem_waddr_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_c[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_dual_port_ram_be.sv
// Directed bench for dual_port_ram_be: three instances (default, no-bypass,
// output-register) share one stimulus stream and are checked against hand values.
module tb_dual_port_ram_be;
  logic        clk;
  logic        reset;
  logic        init_start;
  logic [4:0]  waddr;
  logic [31:0] din;
  logic        write_en;
  logic [3:0]  byte_en;
  logic [4:0]  raddr;
  logic        read_en;

  int checks;
  int errors;
  int cnt;
  logic vseen;

  dual_port_ram_be_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if0 ();
  dual_port_ram_be_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if1 ();
  dual_port_ram_be_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8)) if2 ();

  assign if0.init_start = init_start;
  assign if0.waddr      = waddr;
  assign if0.din        = din;
  assign if0.write_en   = write_en;
  assign if0.byte_en    = byte_en;
  assign if0.raddr      = raddr;
  assign if0.read_en    = read_en;
  assign if1.init_start = init_start;
  assign if1.waddr      = waddr;
  assign if1.din        = din;
  assign if1.write_en   = write_en;
  assign if1.byte_en    = byte_en;
  assign if1.raddr      = raddr;
  assign if1.read_en    = read_en;
  assign if2.init_start = init_start;
  assign if2.waddr      = waddr;
  assign if2.din        = din;
  assign if2.write_en   = write_en;
  assign if2.byte_en    = byte_en;
  assign if2.raddr      = raddr;
  assign if2.read_en    = read_en;

  dual_port_ram_be #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUTPUT_REG(0), .RDW_BYPASS(1))
    u0 (.clk(clk), .reset(reset), .bus(if0));
  dual_port_ram_be #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUTPUT_REG(0), .RDW_BYPASS(0))
    u1 (.clk(clk), .reset(reset), .bus(if1));
  dual_port_ram_be #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYTE_WIDTH(8), .OUTPUT_REG(1), .RDW_BYPASS(1))
    u2 (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    waddr    = a;
    din      = d;
    byte_en  = be;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    cnt = 0;
    while (if0.busy && cnt < 40) begin
      tick();
      cnt++;
    end
    check(tag, 32'(cnt), 32'd32);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; init_start = 1'b0; waddr = '0; din = '0;
    write_en = 1'b0; byte_en = '0; raddr = '0; read_en = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_busy0", 32'(if0.busy), 32'd1);
    check("rst_dout0", if0.dout, 32'd0);
    check("rst_valid0", 32'(if0.dout_valid), 32'd0);
    check("rst_busy2", 32'(if2.busy), 32'd1);
    check("rst_dout2", if2.dout, 32'd0);
    check("rst_valid2", 32'(if2.dout_valid), 32'd0);

    // 1: init length after reset, then every word reads zero with latency 1
    tick(); tick(); tick();
    reset = 1'b0;
    count_busy("init_len");
    check("busy1_ready", 32'(if1.busy), 32'd0);
    check("busy2_ready", 32'(if2.busy), 32'd0);
    read_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr = 5'(a);
      tick();
      check("zero_valid", 32'(if0.dout_valid), 32'd1);
      check("zero_data", if0.dout, 32'd0);
    end
    read_en = 1'b0;
    tick();
    check("zero_valid_off", 32'(if0.dout_valid), 32'd0);
    check("zero_u2_last_valid", 32'(if2.dout_valid), 32'd1);

    // 2: byte lanes
    wr(5'd3, 32'hAABBCCDD, 4'b1111);
    wr(5'd3, 32'h11223344, 4'b0101);
    raddr = 5'd3; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check("lane_u0", if0.dout, 32'hAA22CC44);
    check("lane_u0_valid", 32'(if0.dout_valid), 32'd1);
    check("lane_u1", if1.dout, 32'hAA22CC44);
    check("lane_u2_early_valid", 32'(if2.dout_valid), 32'd0);
    tick();
    check("lane_u2", if2.dout, 32'hAA22CC44);
    check("lane_u2_valid", 32'(if2.dout_valid), 32'd1);
    check("lane_u0_hold_valid", 32'(if0.dout_valid), 32'd0);
    check("lane_u0_hold", if0.dout, 32'hAA22CC44);

    // 3: read-during-write to the same address
    waddr = 5'd7; din = 32'hDEADBEEF; byte_en = 4'b0011; write_en = 1'b1;
    raddr = 5'd7; read_en = 1'b1;
    tick();
    write_en = 1'b0;
    check("rdw_bypass", if0.dout, 32'h0000BEEF);
    check("rdw_nobypass", if1.dout, 32'h00000000);
    tick();
    read_en = 1'b0;
    check("rdw_next_u0", if0.dout, 32'h0000BEEF);
    check("rdw_next_u1", if1.dout, 32'h0000BEEF);
    check("rdw_u2_first", if2.dout, 32'h0000BEEF);
    tick();
    check("rdw_u2_second", if2.dout, 32'h0000BEEF);
    check("rdw_u2_valid", 32'(if2.dout_valid), 32'd1);

    // 4: pipelined back-to-back reads
    wr(5'd0, 32'h10, 4'hF);
    wr(5'd1, 32'h11, 4'hF);
    wr(5'd2, 32'h12, 4'hF);
    wr(5'd3, 32'h13, 4'hF);
    read_en = 1'b1;
    raddr = 5'd0; tick();
    check("pipe_u2_v0", 32'(if2.dout_valid), 32'd0);
    check("pipe_u0_d0", if0.dout, 32'h10);
    raddr = 5'd1; tick();
    check("pipe_u2_v1", 32'(if2.dout_valid), 32'd1);
    check("pipe_u2_d1", if2.dout, 32'h10);
    check("pipe_u0_d1", if0.dout, 32'h11);
    raddr = 5'd2; tick();
    check("pipe_u2_d2", if2.dout, 32'h11);
    raddr = 5'd3; tick();
    check("pipe_u2_d3", if2.dout, 32'h12);
    check("pipe_u0_d3", if0.dout, 32'h13);
    read_en = 1'b0; tick();
    check("pipe_u2_v4", 32'(if2.dout_valid), 32'd1);
    check("pipe_u2_d4", if2.dout, 32'h13);
    tick();
    check("pipe_u2_v5", 32'(if2.dout_valid), 32'd0);
    check("pipe_u2_hold", if2.dout, 32'h13);

    // 5: init_start with a colliding write, user traffic ignored while busy
    wr(5'd5, 32'h55, 4'hF);
    wr(5'd9, 32'h12345678, 4'hF);
    raddr = 5'd9; read_en = 1'b1; tick(); read_en = 1'b0;
    check("pre_init_read", if0.dout, 32'h12345678);
    init_start = 1'b1; waddr = 5'd6; din = 32'h99; byte_en = 4'hF; write_en = 1'b1;
    tick();
    init_start = 1'b0;
    check("init_busy0", 32'(if0.busy), 32'd1);
    check("init_busy2", 32'(if2.busy), 32'd1);
    check("init_u2_inflight", if2.dout, 32'h12345678);
    waddr = 5'd5; din = 32'h77; raddr = 5'd5; read_en = 1'b1;
    vseen = 1'b0;
    cnt = 0;
    while (if0.busy && cnt < 40) begin
      tick();
      cnt++;
      if (if0.dout_valid || if1.dout_valid || if2.dout_valid) vseen = 1'b1;
    end
    write_en = 1'b0; read_en = 1'b0;
    check("reinit_len", 32'(cnt), 32'd32);
    check("reinit_no_valid", 32'(vseen), 32'd0);
    check("reinit_dout_hold", if0.dout, 32'h12345678);
    raddr = 5'd5; read_en = 1'b1; tick();
    check("reinit_a5_u0", if0.dout, 32'd0);
    check("reinit_a5_u1", if1.dout, 32'd0);
    raddr = 5'd6; tick();
    read_en = 1'b0;
    check("reinit_a6_u0", if0.dout, 32'd0);
    check("reinit_a6_u1", if1.dout, 32'd0);
    check("reinit_a5_u2", if2.dout, 32'd0);
    tick();
    check("reinit_a6_u2", if2.dout, 32'd0);
    check("reinit_a6_u2_valid", 32'(if2.dout_valid), 32'd1);

    // 6: reset in the middle of INIT
    wr(5'd9, 32'hCAFEF00D, 4'hF);
    raddr = 5'd9; read_en = 1'b1; tick(); read_en = 1'b0;
    tick();
    check("pre_rst_u0", if0.dout, 32'hCAFEF00D);
    check("pre_rst_u2", if2.dout, 32'hCAFEF00D);
    init_start = 1'b1; tick(); init_start = 1'b0;
    repeat (10) tick();
    check("mid_init_busy", 32'(if0.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_busy0", 32'(if0.busy), 32'd1);
    check("async_dout0", if0.dout, 32'd0);
    check("async_valid0", 32'(if0.dout_valid), 32'd0);
    check("async_dout2", if2.dout, 32'd0);
    check("async_valid2", 32'(if2.dout_valid), 32'd0);
    tick(); tick();
    reset = 1'b0;
    count_busy("rst_init_len");
    read_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      raddr = 5'(a);
      tick();
      check("post_rst_zero", if0.dout, 32'd0);
    end
    read_en = 1'b0;
    tick();
    check("post_rst_u2_valid", 32'(if2.dout_valid), 32'd1);
    check("post_rst_u2_zero", if2.dout, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
Parametrised successor to the team's simple dual-port RAM (one write port, one read port, single clock). It adds:
- per-byte write enables
- an explicit read enable with a valid flag
- selectable read latency
- configurable read-during-write bypass
- a hardware zero-initialisation engine that runs after reset or on request
It is used as register-file, FIFO and scratchpad storage in the MCU and memory subsystems.

Parameters:
- ADDR_WIDTH, 5: address bits; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32: word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.
- OUTPUT_REG, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- RDW_BYPASS, 1: 1 returns new data on a same-address read/write; 0 returns old data.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- init_start  in  1  request to re-zero the whole array; honoured only in READY.
- busy  out  1  high while the init engine owns the array.
- waddr  in  ADDR_WIDTH  write address.
- din  in  DATA_WIDTH  write data.
- write_en  in  1  write strobe.
- byte_en  in  NUM_BYTES  lane enables; lane i covers din[i*BYTE_WIDTH +: BYTE_WIDTH].
- raddr  in  ADDR_WIDTH  read address.
- read_en  in  1  read strobe.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  one-cycle pulse marking new read data on dout.

Behaviour:
- Reset state: FSM=INIT, init_addr=0, busy=1, dout=0, dout_valid=0, all pipeline valids=0. Array contents are not reset directly.
- FSM states: INIT, READY.
- INIT:
  - Each clock writes all-zero to mem[init_addr], then init_addr increments.
  - When the write to address 2**ADDR_WIDTH-1 completes, the FSM goes to READY and busy falls on the same edge.
  - INIT therefore lasts exactly 2**ADDR_WIDTH clocks after reset deasserts.
  - User write_en and read_en are ignored; dout_valid stays 0.
- READY → INIT: when init_start=1 on a clock edge, init_addr is cleared and busy rises on that edge. Any user write in that same cycle is dropped.
- Writes (READY only): on an edge with write_en=1, each lane i with byte_en[i]=1 updates mem[waddr] lane i. Lanes with byte_en[i]=0 keep their value. write_en=1 with byte_en=0 is a no-op.
- Reads (READY only):
  - raddr is sampled on an edge with read_en=1.
  - OUTPUT_REG=0: data appears on dout and dout_valid=1 one cycle later.
  - OUTPUT_REG=1: the same happens two cycles later.
  - Back-to-back reads are fully pipelined, one per cycle.
  - dout holds its last value when no read completes.
- Read-during-write to the same address in the same cycle:
  - RDW_BYPASS=1: enabled lanes return din, disabled lanes return the old memory data.
  - RDW_BYPASS=0: the full old word is returned.
  - Different addresses never interact.
- A write at cycle N followed by a read of the same address at N+1 returns the new data in both modes.
- Reads in flight when init_start is taken complete normally with pre-init data; new reads during INIT are ignored.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous). The in-flight pipeline is discarded. INIT restarts from address 0 after reset is released.
- Address arithmetic wraps modulo 2**ADDR_WIDTH; init_addr never exceeds the top address.

Test Plan:
1. Defaults. Release reset, count cycles with busy=1 → expect exactly 32. Then read all addresses → every word 0x00000000, one dout_valid per read, latency 1.
2. Byte lanes. Write 0xAABBCCDD to address 3 with byte_en=4'b1111, then 0x11223344 with byte_en=4'b0101 → read of address 3 returns 0xAA22CC44.
3. Read-during-write, RDW_BYPASS=1. Address 7 holds 0x0; same-cycle write 0xDEADBEEF with byte_en=4'b0011 and read of 7 → dout=0x0000BEEF. Repeat with RDW_BYPASS=0 → dout=0x00000000. Next-cycle read returns 0x0000BEEF in both cases.
4. OUTPUT_REG=1. Issue read_en on 4 consecutive cycles to addresses 0..3, preloaded with 0x10..0x13 → dout_valid high for 4 cycles starting 2 cycles after the first read, data 0x10,0x11,0x12,0x13 in order.
5. init_start. Fill address 5 with 0x55, pulse init_start together with a write of 0x99 to address 6 → busy high for 32 cycles, user writes and reads ignored meanwhile. Afterwards addresses 5 and 6 read 0x0.
6. Mid-INIT reset. Assert reset at INIT cycle 10 → busy, dout and dout_valid held at reset values. After release, busy stays high for a full 32 cycles and all addresses read 0.
